// File: rtl/poci_pkg.sv
// Shared types and constants for the POCI register bank.
// Parity helper is only referenced when POCI_PARITY_EN is defined.
package poci_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } poci_state_e;

   localparam logic [7:0] CHIP_ID_DEF = 8'hA5;
   localparam int         RSVD_ADDR   = 0;

   // Bit that makes the total count of ones (data + parity) odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~(^d);
   endfunction

endpackage

// File: rtl/poci_reg_bank_if.sv
// Decoder-to-register-bank bus: write/read-load strobes plus the serial return path.
interface poci_reg_bank_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_load;
   logic [ADDR_W-1:0] rd_addr;
   logic              poci;
   logic              busy;

   modport master (output wr_en, wr_addr, wr_data, rd_load, rd_addr, input poci, busy);
   modport slave  (input wr_en, wr_addr, wr_data, rd_load, rd_addr, output poci, busy);
endinterface

// File: rtl/poci_serializer.sv
// MSB-first frame serializer with back-to-back reload and sticky overrun flag.
// POCI_PARITY_EN appends an odd-parity bit after bit0.
module poci_serializer
   import poci_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              sclk,
   input  logic              rstn,
   input  logic              load,
   input  logic [DATA_W-1:0] din,
   output logic              poci,
   output logic              busy,
   output logic              ovr_err
);
`ifdef POCI_PARITY_EN
   localparam int FRAME_W = DATA_W + 1;
`else
   localparam int FRAME_W = DATA_W;
`endif
   localparam int              CNT_W = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

   poci_state_e        state_q, state_d;
   logic [FRAME_W-1:0] shreg_q, shreg_d, frame;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               poci_q, poci_d, busy_q, busy_d, ovr_q, ovr_d;
   logic               start;

`ifdef POCI_PARITY_EN
   assign frame = {din, odd_parity(din)};
`else
   assign frame = din;
`endif

   // A load is accepted when idle or exactly on the last bit of a frame.
   assign start = load && (state_q == IDLE || cnt_q == LAST);

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      poci_d  = poci_q;
      busy_d  = busy_q;
      ovr_d   = ovr_q;
      case (state_q)
         IDLE: ;
         SHIFT: begin
            if (cnt_q == LAST) begin
               state_d = IDLE;
               shreg_d = '0;
               cnt_d   = '0;
               poci_d  = 1'b0;
               busy_d  = 1'b0;
            end else begin
               shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
               poci_d  = shreg_q[FRAME_W-2];
               cnt_d   = cnt_q + 1'b1;
               if (load) ovr_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d = SHIFT;
         shreg_d = frame;
         poci_d  = frame[FRAME_W-1];
         cnt_d   = '0;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         poci_q  <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         poci_q  <= poci_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
      end
   end

   assign poci    = poci_q;
   assign busy    = busy_q;
   assign ovr_err = ovr_q;
endmodule

// File: rtl/poci_reg_bank.sv
// Configuration register bank with flat output bus and POCI readback serializer.
// Optional POCI_PARITY_EN (in poci_serializer) adds an odd-parity bit per frame.
module poci_reg_bank
   import poci_pkg::*;
#(
   parameter int              NUM_REGS = 16,
   parameter int              DATA_W   = 8,
   parameter int              ADDR_W   = 8,
   parameter logic [DATA_W-1:0] CHIP_ID = CHIP_ID_DEF
) (
   input  logic                       sclk,
   input  logic                       rstn,
   poci_reg_bank_if.slave             bus,
   output logic                       ovr_err,
   output logic                       addr_err,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat
);
   localparam int                IDX_W  = $clog2(NUM_REGS);
   localparam logic [ADDR_W-1:0] NREG_A = ADDR_W'(NUM_REGS);
   localparam logic [ADDR_W-1:0] RSVD_A = ADDR_W'(RSVD_ADDR);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              addr_err_q, addr_err_d;
   logic              wr_oob, rd_oob, rd_reg;
   logic [DATA_W-1:0] rd_src;

   assign wr_oob = bus.wr_addr >= NREG_A;
   assign rd_oob = bus.rd_addr >= NREG_A;
   assign rd_reg = !rd_oob && bus.rd_addr != RSVD_A;

   always_comb begin
      regs_d[0] = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) regs_d[i] = bus.wr_data;
      end
   end

   // Same-edge write to the register being loaded wins over the stale value.
   always_comb begin
      rd_src = '0;
      if (bus.rd_addr == RSVD_A)
         rd_src = CHIP_ID;
      else if (rd_reg && bus.wr_en && bus.wr_addr == bus.rd_addr)
         rd_src = bus.wr_data;
      else if (rd_reg)
         rd_src = regs_q[bus.rd_addr[IDX_W-1:0]];
   end

   assign addr_err_d = addr_err_q | (bus.wr_en & wr_oob) | (bus.rd_load & rd_oob);

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         addr_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
         addr_err_q <= addr_err_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
         assign regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
      end
   endgenerate

   poci_serializer #(.DATA_W(DATA_W)) u_ser (
      .sclk    (sclk),
      .rstn    (rstn),
      .load    (bus.rd_load),
      .din     (rd_src),
      .poci    (bus.poci),
      .busy    (bus.busy),
      .ovr_err (ovr_err)
   );

   assign addr_err = addr_err_q;
endmodule

// File: tb/tb_poci_reg_bank.sv
// Directed bench for poci_reg_bank; build with +define+POCI_PARITY_EN for 9-bit frames.
module tb_poci_reg_bank;
`ifdef POCI_PARITY_EN
   localparam int FW = 9;
`else
   localparam int FW = 8;
`endif

   logic         sclk = 1'b0;
   logic         rstn = 1'b0;
   logic         ovr_err, addr_err;
   logic [127:0] regs_flat;
   logic [127:0] exp_flat = '0;
   int           checks = 0;
   int           failures = 0;

   always #5 sclk = ~sclk;

   poci_reg_bank_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   poci_reg_bank dut (
      .sclk      (sclk),
      .rstn      (rstn),
      .bus       (bus),
      .ovr_err   (ovr_err),
      .addr_err  (addr_err),
      .regs_flat (regs_flat)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   function automatic logic [8:0] mk_frame(input logic [7:0] b);
`ifdef POCI_PARITY_EN
      return {b, ~(^b)};
`else
      return {1'b0, b};
`endif
   endfunction

   task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      step();
      bus.wr_en = 1'b0;
      if (a >= 8'd1 && a < 8'd16) exp_flat[int'(a)*8 +: 8] = d;
   endtask

   task automatic start_read(input logic [7:0] a);
      bus.rd_load = 1'b1; bus.rd_addr = a;
      step();
      bus.rd_load = 1'b0;
   endtask

   // Called just after the load edge; optionally pulses rd_load while bit rl_k is on poci.
   task automatic run_frame(input string tag, input logic [7:0] b, input int rl_k, input logic [7:0] rl_addr);
      logic [8:0] frm;
      frm = mk_frame(b);
      for (int k = 0; k < FW; k++) begin
         check($sformatf("%s bit%0d", tag, k), 128'(bus.poci), 128'(frm[FW-1-k]));
         check($sformatf("%s busy%0d", tag, k), 128'(bus.busy), 128'd1);
         if (k == rl_k) begin
            bus.rd_load = 1'b1; bus.rd_addr = rl_addr;
         end
         step();
         bus.rd_load = 1'b0;
      end
      if (rl_k != FW - 1) begin
         check({tag, " idle_poci"}, 128'(bus.poci), 128'd0);
         check({tag, " idle_busy"}, 128'(bus.busy), 128'd0);
      end
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.rd_load = 1'b0; bus.rd_addr = '0;
      step(); step();
      check("rst poci", 128'(bus.poci), 128'd0);
      check("rst busy", 128'(bus.busy), 128'd0);
      check("rst regs", regs_flat, 128'd0);
      check("rst ovr", 128'(ovr_err), 128'd0);
      check("rst aerr", 128'(addr_err), 128'd0);
      rstn = 1'b1;
      step();

      write_reg(8'd5, 8'h3C);
      check("wr5 slice", 128'(regs_flat[47:40]), 128'h3C);
      start_read(8'd5);
      run_frame("rd5", 8'h3C, -1, 8'd0);

      start_read(8'd0);
      run_frame("rd0", 8'hA5, -1, 8'd0);

      write_reg(8'd0, 8'h77);
      check("wr0 regs", regs_flat, exp_flat);
      check("wr0 aerr", 128'(addr_err), 128'd0);
      write_reg(8'd20, 8'h55);
      check("wr20 regs", regs_flat, exp_flat);
      check("wr20 aerr", 128'(addr_err), 128'd1);
      start_read(8'd20);
      run_frame("rd20", 8'h00, -1, 8'd0);

      write_reg(8'd3, 8'hFF);
      write_reg(8'd4, 8'h00);
      check("b2b regs", regs_flat, exp_flat);
      start_read(8'd3);
      run_frame("b2b_a", 8'hFF, FW - 1, 8'd4);
      run_frame("b2b_b", 8'h00, -1, 8'd0);
      check("b2b ovr", 128'(ovr_err), 128'd0);

      start_read(8'd5);
      run_frame("ovr", 8'h3C, 3, 8'd3);
      check("ovr flag", 128'(ovr_err), 128'd1);

      bus.wr_en = 1'b1; bus.wr_addr = 8'd2; bus.wr_data = 8'h81;
      bus.rd_load = 1'b1; bus.rd_addr = 8'd2;
      step();
      bus.wr_en = 1'b0; bus.rd_load = 1'b0;
      exp_flat[23:16] = 8'h81;
      check("byp regs", regs_flat, exp_flat);
      run_frame("byp", 8'h81, -1, 8'd0);

      start_read(8'd3);
      step(); step();
      check("mid busy", 128'(bus.busy), 128'd1);
      #2 rstn = 1'b0;
      #1;
      check("arst poci", 128'(bus.poci), 128'd0);
      check("arst busy", 128'(bus.busy), 128'd0);
      check("arst regs", regs_flat, 128'd0);
      check("arst ovr", 128'(ovr_err), 128'd0);
      check("arst aerr", 128'(addr_err), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/poci_reg_bank.md
Name: poci_reg_bank

Overview:
- Downstream consumer of the serial-in command decoder's write_data / address-pointer outputs.
- Holds the chip's configuration register bank and drives all registers out as a flat bus to the analog core.
- Serializes the addressed register back to the SPI master on POCI, MSB first.
- Runs entirely on the SPI clock; the decoder supplies a one-cycle write strobe and a one-cycle read-load strobe on message boundaries.

Parameters:
- NUM_REGS, 16: number of registers; valid indices 1..NUM_REGS-1; index 0 is reserved.
- DATA_W, 8: register and serial frame width.
- ADDR_W, 8: width of wr_addr and rd_addr.
- CHIP_ID, 8'hA5: constant returned when reading address 0.

Ports:
- sclk  in  1  SPI clock; single clock, all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe, one sclk cycle wide.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_load  in  1  strobe: capture reg[rd_addr] and start shifting.
- rd_addr  in  ADDR_W  read address.
- poci  out  1  serial data out, MSB first.
- busy  out  1  high while a frame is being shifted.
- ovr_err  out  1  sticky: a read load was dropped.
- addr_err  out  1  sticky: out-of-range write or read.
- regs_flat  out  NUM_REGS*DATA_W  all registers; reg i at bits [i*DATA_W +: DATA_W]; slice 0 is tied to 0.

Behaviour:
- Reset (rstn low, asynchronous): all registers 0; shift register 0; state IDLE; bit_cnt 0; poci 0; busy 0; ovr_err 0; addr_err 0. Reset mid-frame aborts the frame immediately.
- Write path:
  - wr_en at posedge with 1 <= wr_addr < NUM_REGS: reg[wr_addr] <= wr_data, visible on regs_flat the next cycle.
  - wr_addr == 0: write ignored, no error.
  - wr_addr >= NUM_REGS: write ignored, addr_err <= 1.
- Read source:
  - rd_addr 0 gives CHIP_ID.
  - rd_addr 1..NUM_REGS-1 gives reg[rd_addr].
  - rd_addr >= NUM_REGS gives 8'h00 and sets addr_err <= 1.
  - Write-first bypass: wr_en and rd_load on the same edge with equal valid addresses load wr_data.
- State machine:
  - IDLE, rd_load: shreg <= source; poci <= source[7]; bit_cnt <= 0; state SHIFT; busy 1.
  - SHIFT, bit_cnt < 7: shift left, poci <= next bit, bit_cnt += 1.
  - SHIFT, bit_cnt == 7, no load: state IDLE; poci <= 0; busy 0.
  - SHIFT, bit_cnt == 7, rd_load: back-to-back reload; new frame MSB on poci with no gap; stays SHIFT.
  - SHIFT, bit_cnt < 7, rd_load: load dropped; ovr_err <= 1; current frame continues unchanged.
- Timing: load at edge N puts bit7 on poci after N; bit k appears after edge N+7-k; poci returns to 0 after edge N+8.
- Sticky flags clear only on rstn.

Optional Feature:
- Macro POCI_PARITY_EN.
- Defined:
  - Frame becomes DATA_W+1 bits: an odd-parity bit of the captured byte follows bit0.
  - bit_cnt runs 0..8; reload and overrun decisions use bit_cnt == 8.
  - busy lasts 9 cycles.
- Undefined: 8-bit frames as above; no parity logic is synthesized.

Decomposition:
- Package poci_pkg holds:
  - state enum typedef {IDLE, SHIFT};
  - localparams for CHIP_ID default and the reserved address 0;
  - a function computing odd parity.
- One natural sub-module, poci_serializer: shift register, bit counter, FSM, poci, busy, ovr_err. It takes a parallel byte and a load strobe.
- The top holds the register array, address decode, bypass mux, and addr_err.

Test Plan:
- Reset check: assert rstn low mid-frame -> poci=0, busy=0, regs_flat all 0, both flags 0 asynchronously.
- Write then read: write 8'h3C to addr 5, then rd_load with rd_addr=5 -> poci bits 0,0,1,1,1,1,0,0 on 8 consecutive cycles; regs_flat[47:40]=8'h3C.
- Reserved and out-of-range: read addr 0 -> 10100101; write addr 0 -> regs_flat unchanged, addr_err=0; write addr 20 -> addr_err=1; read addr 20 -> 8'h00.
- Back-to-back frames: rd_load at bit_cnt==7 for regs holding 8'hFF then 8'h00 -> 16 contiguous bits, no idle gap, busy continuously high.
- Overrun: rd_load at bit_cnt==3 -> ovr_err=1, current frame bits unchanged.
- Bypass and parity: wr_en+rd_load on the same edge to addr 2, data 8'h81 -> frame 10000001; with POCI_PARITY_EN -> 9th bit 1.
